// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared sizing constants for the 1-to-8 demultiplexer
package demux_pkg;
    localparam int DEFAULT_WIDTH = 3;
    localparam int SEL_W         = 3;
    localparam int NUM_OUT       = 8;
endpackage

// File: rtl/demux1x8_if.sv
// rtl/demux1x8_if.sv - routed data, select/enable inputs and registered outputs of demux1x8
interface demux1x8_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]   I;
    logic [SEL_W-1:0]   S;
    logic               E;
    logic [WIDTH-1:0]   I1, I2, I3, I4, I5, I6, I7, I8;
    logic [NUM_OUT-1:0] V;

    modport master (
        output I, S, E,
        input  I1, I2, I3, I4, I5, I6, I7, I8, V
    );

    modport slave (
        input  I, S, E,
        output I1, I2, I3, I4, I5, I6, I7, I8, V
    );
endinterface

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - enable-gated 3-to-8 one-hot decoder
module decoder3to8
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]   s_i,
    input  logic               e_i,
    output logic [NUM_OUT-1:0] mask_o
);
    always_comb begin
        mask_o = '0;
        if (e_i) begin
            mask_o = NUM_OUT'(1) << s_i;
        end
    end
endmodule

// File: rtl/demux1x8.sv
// rtl/demux1x8.sv - registered 1-to-8 demultiplexer with one-hot valid
module demux1x8
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    demux1x8_if.slave bus
);
    logic [NUM_OUT-1:0] mask;
    logic [WIDTH-1:0]   out_d [NUM_OUT];
    logic [WIDTH-1:0]   out_q [NUM_OUT];
    logic [NUM_OUT-1:0] v_q;

    decoder3to8 u_dec (
        .s_i    (bus.S),
        .e_i    (bus.E),
        .mask_o (mask)
    );

    // The mask is zero when disabled, so every lane clears on the same edge.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = bus.I & {WIDTH{mask[k]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
            v_q <= mask;
        end
    end

    assign bus.I1 = out_q[0];
    assign bus.I2 = out_q[1];
    assign bus.I3 = out_q[2];
    assign bus.I4 = out_q[3];
    assign bus.I5 = out_q[4];
    assign bus.I6 = out_q[5];
    assign bus.I7 = out_q[6];
    assign bus.I8 = out_q[7];
    assign bus.V  = v_q;
endmodule

// File: tb/tb_demux1x8.sv
// tb/tb_demux1x8.sv - directed and randomized checks of demux1x8 against a behavioural model
module tb_demux1x8;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [W-1:0] exp_out [8];
    logic [7:0]   exp_v;

    demux1x8_if #(.WIDTH(W)) bus ();

    demux1x8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the chosen output mirrors the input, everything else is zero.
    task automatic model(input logic e, input int s, input logic [W-1:0] d);
        exp_v = 8'h00;
        for (int k = 0; k < 8; k++) exp_out[k] = '0;
        if (e) begin
            exp_out[s] = d;
            exp_v      = 8'(2 ** s);
        end
    endtask

    task automatic model_zero();
        exp_v = 8'h00;
        for (int k = 0; k < 8; k++) exp_out[k] = '0;
    endtask

    task automatic check(input string tag);
        logic [W-1:0] got [8];
        got[0] = bus.I1; got[1] = bus.I2; got[2] = bus.I3; got[3] = bus.I4;
        got[4] = bus.I5; got[5] = bus.I6; got[6] = bus.I7; got[7] = bus.I8;
        for (int k = 0; k < 8; k++) begin
            tests++;
            assert (got[k] === exp_out[k]) else begin
                fails++;
                $error("FAIL %s out%0d observed=%b expected=%b", tag, k + 1, got[k], exp_out[k]);
            end
        end
        tests++;
        assert (bus.V === exp_v) else begin
            fails++;
            $error("FAIL %s V observed=%h expected=%h", tag, bus.V, exp_v);
        end
    endtask

    task automatic drive(input logic e, input int s, input logic [W-1:0] d);
        bus.E = e;
        bus.S = 3'(s);
        bus.I = d;
    endtask

    // Apply inputs, clock once, then compare just after the edge.
    task automatic step(input logic e, input int s, input logic [W-1:0] d, input string tag);
        drive(e, s, d);
        @(posedge clk);
        #1;
        model(e, s, d);
        check(tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        drive(1'b1, 3, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        model_zero();
        check("reset_immediate");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("reset_hold");
        end
        #2;
        rst_n = 1'b1;

        for (int s = 0; s < 8; s++) step(1'b0, s, 3'(s), "disabled_sweep");
        for (int s = 0; s < 8; s++) step(1'b1, s, 3'(s), "enabled_sweep");

        step(1'b1, 0, 3'b000, "zero_data");

        step(1'b1, 7, 3'b110, "disable_mid_first");
        step(1'b0, 7, 3'b110, "disable_mid_after");

        // Inputs wiggling between edges must not disturb registered outputs.
        step(1'b1, 4, 3'b101, "hold_load");
        drive(1'b1, 1, 3'b011);
        #3;
        check("hold_between_edges");

        step(1'b1, 2, 3'b011, "async_load");
        #3;
        rst_n = 1'b0;
        #1;
        model_zero();
        check("async_mid_cycle");
        #1;
        rst_n = 1'b1;
        step(1'b1, 6, 3'b010, "first_after_reset");

        for (int n = 0; n < 200; n++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), W'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
